// File: rtl/controller_multi_cycle.sv
`default_nettype none
// ============================================================================
// controller_multi_cycle : RV32I multi-cycle control unit (Moore FSM + decode)
// Revision 1.0
// ============================================================================
module controller_multi_cycle #(
  parameter int ALU_CTRL_W    = 3,
  parameter bit SUPPORT_UPPER = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  input  logic                  LT,
  input  logic                  LTU,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [2:0]            ImmSrc,
  output logic                  RegWrite,
  output logic                  illegal_instr,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_LINK     = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_xor = 3'b100;
  localparam logic [2:0] c_alu_slt = 3'b101;
  localparam logic [2:0] c_alu_sll = 3'b110;
  localparam logic [2:0] c_alu_srl = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_alu_dec;
  logic [2:0] w_alu;
  logic       w_taken;
  logic       w_pcwrite;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  // ALU operation for R/I-type execute; sub only for R-type with bit30 set
  always_comb begin
    w_alu_dec = c_alu_add;
    case (funct3)
      3'b000:  w_alu_dec = (funct7b5 & op[5]) ? c_alu_sub : c_alu_add;
      3'b001:  w_alu_dec = c_alu_sll;
      3'b010:  w_alu_dec = c_alu_slt;
      3'b100:  w_alu_dec = c_alu_xor;
      3'b101:  w_alu_dec = c_alu_srl;
      3'b110:  w_alu_dec = c_alu_or;
      3'b111:  w_alu_dec = c_alu_and;
      default: w_alu_dec = c_alu_add;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = LT;
      3'b101:  w_taken = ~LT;
      3'b110:  w_taken = LTU;
      3'b111:  w_taken = ~LTU;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    w_alu      = c_alu_add;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          7'b1100111:             w_next = S_JALR;
          7'b0110111:             w_next = SUPPORT_UPPER ? S_LUI : S_TRAP;
          7'b0010111:             w_next = SUPPORT_UPPER ? S_AUIPC : S_TRAP;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        w_memread = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        w_alu   = w_alu_dec;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_alu   = w_alu_dec;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        w_alu   = c_alu_sub;
        // funct3 010/011 has no branch meaning and traps without redirecting
        if (funct3[2:1] == 2'b01) begin
          w_next = S_TRAP;
        end else begin
          w_pcwrite = w_taken;
          w_next    = S_FETCH;
        end
      end
      S_JAL: begin
        w_pcwrite = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        if (funct3 == 3'b000) begin
          w_pcwrite = 1'b1;
          w_next    = S_LINK;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_next  = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        w_next  = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        w_next  = S_ALUWB;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are masked by reset so an access in flight drops immediately
  assign PCWrite       = resetn & w_pcwrite;
  assign MemRead       = resetn & w_memread;
  assign MemWrite      = resetn & w_memwrite;
  assign IRWrite       = resetn & w_irwrite;
  assign RegWrite      = resetn & w_regwrite;
  assign ALUControl    = ALU_CTRL_W'(w_alu);
  assign illegal_instr = (r_state == S_TRAP);
  assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_controller_multi_cycle.sv
`default_nettype none
// ============================================================================
// tb_controller_multi_cycle : directed self-checking bench for the controller
// Revision 1.0
// ============================================================================
module tb_controller_multi_cycle;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       LT = 1'b0;
  logic       LTU = 1'b0;
  logic       mem_ready = 1'b0;

  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state_o;

  logic       nu_PCWrite, nu_AdrSrc, nu_MemRead, nu_MemWrite, nu_IRWrite, nu_RegWrite, nu_illegal;
  logic [1:0] nu_ResultSrc, nu_ALUSrcA, nu_ALUSrcB;
  logic [2:0] nu_ALUControl, nu_ImmSrc;
  logic [3:0] nu_state;

  int tests = 0;
  int fails = 0;

  logic [3:0] lw_states [0:10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
  logic       lw_ready  [0:10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  controller_multi_cycle #(.ALU_CTRL_W(3), .SUPPORT_UPPER(1'b1)) dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  controller_multi_cycle #(.ALU_CTRL_W(3), .SUPPORT_UPPER(1'b0)) dut_nu (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
    .PCWrite(nu_PCWrite), .AdrSrc(nu_AdrSrc), .MemRead(nu_MemRead), .MemWrite(nu_MemWrite),
    .IRWrite(nu_IRWrite), .ResultSrc(nu_ResultSrc), .ALUSrcA(nu_ALUSrcA), .ALUSrcB(nu_ALUSrcB),
    .ALUControl(nu_ALUControl), .ImmSrc(nu_ImmSrc), .RegWrite(nu_RegWrite),
    .illegal_instr(nu_illegal), .state_o(nu_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; mem_ready = 1'b0; Zero = 1'b0; LT = 1'b0; LTU = 1'b0;
    funct3 = 3'd0; funct7b5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    tests++; if (MemRead !== 1'b0) begin fails++; $display("FAIL reset_memread: got %b expected 0", MemRead); end
    tests++; if (state_o !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    apply_reset();
    op = 7'b0100011; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    step();
    tests++; if (state_o !== 4'd5) begin fails++; $display("FAIL sw_stall_state: got %0d expected 5", state_o); end
    tests++; if (MemWrite !== 1'b1 || AdrSrc !== 1'b1) begin fails++; $display("FAIL sw_memwrite: got %b/%b expected 1/1", MemWrite, AdrSrc); end
    resetn = 1'b0;
    #1;
    tests++; if (MemWrite !== 1'b0) begin fails++; $display("FAIL reset_drops_memwrite: got %b expected 0", MemWrite); end
    tests++; if (state_o !== 4'd0) begin fails++; $display("FAIL reset_mid_state: got %0d expected 0", state_o); end
    tests++; if (illegal_instr !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", illegal_instr); end
    #2;
    resetn = 1'b1;
    #1;
    tests++; if (state_o !== 4'd0 || MemRead !== 1'b1) begin fails++; $display("FAIL release_fetch: state %0d memread %b expected 0/1", state_o, MemRead); end
  endtask

  task automatic test_lw();
    apply_reset();
    op = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 11; i++) begin
      mem_ready = lw_ready[i];
      #1;
      tests++; if (state_o !== lw_states[i]) begin fails++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, lw_states[i]); end
      tests++; if (RegWrite !== (lw_states[i] == 4'd4)) begin fails++; $display("FAIL lw_regwrite[%0d]: got %b expected %b", i, RegWrite, lw_states[i] == 4'd4); end
      if (lw_states[i] == 4'd4) begin
        tests++; if (ResultSrc !== 2'b01) begin fails++; $display("FAIL lw_resultsrc: got %b expected 01", ResultSrc); end
      end
      if (lw_states[i] == 4'd0) begin
        tests++; if (IRWrite !== lw_ready[i]) begin fails++; $display("FAIL lw_irwrite[%0d]: got %b expected %b", i, IRWrite, lw_ready[i]); end
      end
      step();
    end
  endtask

  task automatic test_alu();
    apply_reset();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; mem_ready = 1'b1;
    step();
    step();
    tests++; if (state_o !== 4'd6) begin fails++; $display("FAIL sub_state: got %0d expected 6", state_o); end
    tests++; if (ALUControl !== 3'b001) begin fails++; $display("FAIL sub_aluctl: got %b expected 001", ALUControl); end
    tests++; if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00) begin fails++; $display("FAIL sub_srcs: got %b/%b expected 10/00", ALUSrcA, ALUSrcB); end
    step();
    tests++; if (state_o !== 4'd8 || RegWrite !== 1'b1) begin fails++; $display("FAIL sub_aluwb: state %0d regwrite %b expected 8/1", state_o, RegWrite); end
    step();
    op = 7'b0010011;
    step();
    step();
    tests++; if (state_o !== 4'd7) begin fails++; $display("FAIL addi_state: got %0d expected 7", state_o); end
    tests++; if (ALUControl !== 3'b000 || ALUSrcB !== 2'b01) begin fails++; $display("FAIL addi_aluctl: got %b/%b expected 000/01", ALUControl, ALUSrcB); end
    funct3 = 3'b111;
    #1;
    tests++; if (ALUControl !== 3'b010) begin fails++; $display("FAIL andi_aluctl: got %b expected 010", ALUControl); end
    step();
    step();
  endtask

  task automatic test_branch();
    apply_reset();
    op = 7'b1100011; funct3 = 3'b001; Zero = 1'b0; mem_ready = 1'b1;
    step();
    step();
    tests++; if (state_o !== 4'd9 || PCWrite !== 1'b1) begin fails++; $display("FAIL bne_taken: state %0d pcwrite %b expected 9/1", state_o, PCWrite); end
    tests++; if (ALUControl !== 3'b001) begin fails++; $display("FAIL branch_sub: got %b expected 001", ALUControl); end
    step();
    tests++; if (state_o !== 4'd0) begin fails++; $display("FAIL branch_return: got %0d expected 0", state_o); end
    funct3 = 3'b111; LTU = 1'b1;
    step();
    step();
    tests++; if (state_o !== 4'd9 || PCWrite !== 1'b0) begin fails++; $display("FAIL bgeu_not_taken: state %0d pcwrite %b expected 9/0", state_o, PCWrite); end
    funct3 = 3'b100; LT = 1'b1;
    #1;
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL blt_taken: got %b expected 1", PCWrite); end
    step();
    funct3 = 3'b010;
    step();
    step();
    tests++; if (state_o !== 4'd9 || PCWrite !== 1'b0) begin fails++; $display("FAIL bad_branch_pcwrite: state %0d pcwrite %b expected 9/0", state_o, PCWrite); end
    step();
    for (int i = 0; i < 10; i++) begin
      tests++; if (state_o !== 4'd15 || illegal_instr !== 1'b1) begin fails++; $display("FAIL trap_hold[%0d]: state %0d illegal %b expected 15/1", i, state_o, illegal_instr); end
      tests++; if (MemRead !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0) begin fails++; $display("FAIL trap_enables[%0d]: got %b%b%b expected 000", i, MemRead, PCWrite, RegWrite); end
      step();
    end
  endtask

  task automatic test_jalr();
    apply_reset();
    op = 7'b1100111; funct3 = 3'b000; mem_ready = 1'b1;
    step();
    tests++; if (state_o !== 4'd1) begin fails++; $display("FAIL jalr_decode: got %0d expected 1", state_o); end
    step();
    tests++; if (state_o !== 4'd11) begin fails++; $display("FAIL jalr_state: got %0d expected 11", state_o); end
    tests++; if (PCWrite !== 1'b1 || ResultSrc !== 2'b10) begin fails++; $display("FAIL jalr_pc: pcwrite %b resultsrc %b expected 1/10", PCWrite, ResultSrc); end
    step();
    tests++; if (state_o !== 4'd14 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10) begin fails++; $display("FAIL jalr_link: state %0d A %b B %b expected 14/01/10", state_o, ALUSrcA, ALUSrcB); end
    step();
    tests++; if (state_o !== 4'd8 || RegWrite !== 1'b1) begin fails++; $display("FAIL jalr_aluwb: state %0d regwrite %b expected 8/1", state_o, RegWrite); end
  endtask

  task automatic test_upper();
    apply_reset();
    op = 7'b0110111; mem_ready = 1'b1;
    step();
    step();
    tests++; if (state_o !== 4'd12) begin fails++; $display("FAIL lui_state: got %0d expected 12", state_o); end
    tests++; if (ALUSrcA !== 2'b11 || ALUSrcB !== 2'b01 || ImmSrc !== 3'b100) begin fails++; $display("FAIL lui_ctrl: A %b B %b imm %b expected 11/01/100", ALUSrcA, ALUSrcB, ImmSrc); end
    tests++; if (nu_state !== 4'd15 || nu_illegal !== 1'b1) begin fails++; $display("FAIL lui_no_upper_trap: state %0d illegal %b expected 15/1", nu_state, nu_illegal); end
    step();
    tests++; if (state_o !== 4'd8 || RegWrite !== 1'b1) begin fails++; $display("FAIL lui_aluwb: state %0d regwrite %b expected 8/1", state_o, RegWrite); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu();
    test_branch();
    test_jalr();
    test_upper();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controller_multi_cycle.md
Name: controller_multi_cycle

Overview:
- Multi-cycle RISC-V RV32I control unit; successor to the single-cycle controller.
- Sequences each instruction through a Moore FSM over a shared memory port and a single ALU.
- Adds a memory ready handshake, full branch-condition set (BEQ/BNE/BLT/BGE/BLTU/BGEU), JALR, optional LUI/AUIPC, and illegal-instruction trapping.
- Drives the datapath muxes and enables of the multi-cycle core.

Parameters:
- ALU_CTRL_W, 3, ALUControl width (>=3); codes are zero-extended into upper bits.
- SUPPORT_UPPER, 1, 1 = decode LUI/AUIPC; 0 = those opcodes trap.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- op  in  7  instruction opcode (from IR)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU result == 0
- LT  in  1  signed rs1 < rs2
- LTU  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address
- MemRead  out  1  read request
- MemWrite  out  1  write request
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
- ALUControl  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- RegWrite  out  1  register file write enable
- illegal_instr  out  1  sticky trap flag
- state_o  out  4  current state (debug)

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low. While resetn=0: state=FETCH, illegal_instr=0, and all enables (PCWrite, MemRead, MemWrite, IRWrite, RegWrite) forced to 0. A reset mid-access drops MemWrite immediately. Execution restarts in FETCH on the first edge after release.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, LINK=14, TRAP=15.
- Output timing: outputs are combinational from state; only handshake- and branch-gated enables also depend on inputs. ImmSrc is decoded from op in every state; unknown op gives 000.
- ALU decode (EXECR/EXECI only): funct3 000 → add, or sub iff funct7b5&op[5]; 001 sll; 010 slt; 100 xor; 101 srl; 110 or; 111 and. All other states use an explicit add or sub.
- FETCH: AdrSrc=0, MemRead=1, A=00, B=10, add, ResultSrc=10. IRWrite and PCWrite are asserted only when mem_ready=1, which moves to DECODE; otherwise stay in FETCH.
- DECODE: A=01, B=01, add (branch/JAL target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI, 0010111 → AUIPC (if SUPPORT_UPPER), else TRAP
  - any other op → TRAP
- MEMADR: A=10, B=01, add. Next MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, MemRead=1. Wait for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready, then FETCH.
- EXECR: A=10, B=00. EXECI: A=10, B=01. Both go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00. PCWrite=taken, where taken is selected by funct3:
  - 000 Zero, 001 !Zero
  - 100 LT, 101 !LT
  - 110 LTU, 111 !LTU
  - Next FETCH. funct3 010/011 → TRAP with PCWrite=0.
- JAL: ResultSrc=00, PCWrite=1, A=01, B=10, add (link value), then ALUWB.
- JALR: A=10, B=01, add, ResultSrc=10, PCWrite=1, then LINK. Requires funct3=000, else TRAP.
- LINK: A=01, B=10, add, then ALUWB.
- LUI: A=11, B=01, add. AUIPC: A=01, B=01, add. Both go to ALUWB.
- TRAP: illegal_instr=1, all enables 0, remain in TRAP until reset.
- mem_ready may stay high across states; it is sampled only in FETCH, MEMREAD and MEMWRITE. A stall of any length holds all outputs stable.

Test Plan:
- Reset: resetn=0 mid-MEMWRITE with MemWrite=1 → MemWrite=0 immediately, state_o=0, illegal_instr=0. After release, first FETCH shows MemRead=1.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMREAD → state sequence 0,0,0,0,1,2,3,3,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
- add/sub: R-type, funct3=000, funct7b5=1 → EXECR with ALUControl=001, then ALUWB RegWrite=1. Same with op=0010011 (addi, bit30 set) → ALUControl=000.
- Branches: BNE with Zero=0 → PCWrite=1 in BRANCH. BGEU with LTU=1 → PCWrite=0. funct3=010 → state 15, illegal_instr=1, held for 10 cycles.
- JALR: op=1100111 → states 1,11,14,8. PCWrite=1 with ResultSrc=10 in JALR; RegWrite=1 in ALUWB.
- SUPPORT_UPPER=0: op=0110111 → TRAP. SUPPORT_UPPER=1: LUI → A=11, B=01, ImmSrc=100, then ALUWB.
